fetch_prefetch_queue: RTL

//  Parametrised instruction fetch front end: generates sequential fetch addresses, issues one

---
 rtl/fetch_prefetch_queue_if.sv | 28 ++
 rtl/fetch_prefetch_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: redirect input, icache request/response and decode-side handshake.
// The fetch unit takes the master modport; the surrounding core/icache/decode take slave.
interface fetch_prefetch_queue_if #(
   parameter int XLEN = 32,
   parameter int CW   = 3
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            icache_valid;
   logic [XLEN-1:0] icache_addr;
   logic            icache_ready;
   logic [XLEN-1:0] icache_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_ir;
   logic [XLEN-1:0] out_pc;
   logic [CW-1:0]   count;

   modport master (
      input  redirect_valid, redirect_pc, icache_ready, icache_rdata, out_ready,
      output icache_valid, icache_addr, out_valid, out_ir, out_pc, count
   );

   modport slave (
      output redirect_valid, redirect_pc, icache_ready, icache_rdata, out_ready,
      input  icache_valid, icache_addr, out_valid, out_ir, out_pc, count
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction fetcher with one outstanding icache request and a DEPTH-entry
// {instruction, PC} queue towards decode; redirect flushes queued and in-flight words.
module fetch_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input logic                    clk,
   input logic                    rst_n,
   fetch_prefetch_queue_if.master fq_io
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
   localparam logic [XLEN-1:0] FETCH_STEP = XLEN'(3'd4);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0] ir_q [DEPTH];
   logic [XLEN-1:0] pc_q [DEPTH];

   logic            push_s;
   logic            pop_s;
   logic            space_s;
   logic [CW-1:0]   count_nxt_s;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] fpc_inc_s;

   // Next-state, pointer and occupancy logic; redirect overrides normal sequencing.
   always_comb begin
      pop_s       = (count_q != {CW{1'b0}}) & fq_io.out_ready;
      push_s      = (state_q == S_REQ) & fq_io.icache_ready & ~fq_io.redirect_valid;
      count_nxt_s = count_q + CW'(push_s) - CW'(pop_s);
      space_s     = (count_nxt_s < DEPTH_C);
      target_s    = {fq_io.redirect_pc[XLEN-1:2], 2'b00};
      fpc_inc_s   = fpc_q + FETCH_STEP;
      state_d     = state_q;
      fpc_d       = fpc_q;
      addr_d      = addr_q;
      count_d     = count_nxt_s;
      rd_ptr_d    = rd_ptr_q + PW'(pop_s);
      wr_ptr_d    = wr_ptr_q + PW'(push_s);
      if (fq_io.redirect_valid) begin
         fpc_d    = target_s;
         count_d  = {CW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         case (state_q)
            S_IDLE: begin
               state_d = S_REQ;
               addr_d  = target_s;
            end
            S_REQ, S_DROP: begin
               // An unanswered request cannot be withdrawn; its answer is dropped later.
               if (fq_io.icache_ready) begin
                  state_d = S_REQ;
                  addr_d  = target_s;
               end else begin
                  state_d = S_DROP;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (space_s) begin
                  state_d = S_REQ;
                  addr_d  = fpc_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_REQ: begin
               if (fq_io.icache_ready) begin
                  fpc_d = fpc_inc_s;
                  if (space_s) begin
                     addr_d = fpc_inc_s;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_REQ;
               end
            end
            S_DROP: begin
               if (fq_io.icache_ready) begin
                  if (space_s) begin
                     state_d = S_REQ;
                     addr_d  = fpc_q;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_DROP;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         fpc_q    <= RESET_PC;
         addr_q   <= {XLEN{1'b0}};
         count_q  <= {CW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Queue storage; the pushed PC is the address the icache answered for.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ir_q[i] <= {XLEN{1'b0}};
            pc_q[i] <= {XLEN{1'b0}};
         end
      end else if (push_s) begin
         ir_q[wr_ptr_q] <= fq_io.icache_rdata;
         pc_q[wr_ptr_q] <= addr_q;
      end else begin
         ir_q[wr_ptr_q] <= ir_q[wr_ptr_q];
      end
   end

   assign fq_io.icache_valid = (state_q != S_IDLE);
   assign fq_io.icache_addr  = addr_q;
   assign fq_io.out_valid    = (count_q != {CW{1'b0}});
   assign fq_io.out_ir       = ir_q[rd_ptr_q];
   assign fq_io.out_pc       = pc_q[rd_ptr_q];
   assign fq_io.count        = count_q;
endmodule
